// File: rtl/bram_port_client_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bram_port_client_if
//  Purpose  : Bundles the client request/response handshake and the BRAM port
//             drives of bram_port_client into one interface.
//  Ports    : slave  - view used by bram_port_client (accepts requests,
//                      drives the BRAM port, returns responses)
//             master - view used by the client/BRAM environment
//  Signals  : rd_req_en/rd_req_addr/rd_rdy          read request handshake
//             wr_req_en/wr_req_addr/wr_req_data/wr_rdy  write request handshake
//             rsp_valid/rsp_data/rsp_deq            read response handshake
//             bram_rd_addr/bram_re/bram_wr_addr/bram_we/bram_di  BRAM drives
//             bram_do/bram_init                     BRAM returns
//             outstanding                           reads issued, not dequeued
//  Revision : 1.0 - initial release
// ============================================================================
interface bram_port_client_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9,
  parameter int RSP_DEPTH  = 2
);
  localparam int c_OW = $clog2(RSP_DEPTH) + 1;

  logic                  rd_req_en;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_rdy;
  logic                  wr_req_en;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_rdy;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_deq;
  logic [ADDR_WIDTH-1:0] bram_rd_addr;
  logic                  bram_re;
  logic [ADDR_WIDTH-1:0] bram_wr_addr;
  logic                  bram_we;
  logic [DATA_WIDTH-1:0] bram_di;
  logic [DATA_WIDTH-1:0] bram_do;
  logic                  bram_init;
  logic [c_OW-1:0]       outstanding;

  modport slave (
    input  rd_req_en, rd_req_addr, wr_req_en, wr_req_addr, wr_req_data, rsp_deq,
           bram_do, bram_init,
    output rd_rdy, wr_rdy, rsp_valid, rsp_data,
           bram_rd_addr, bram_re, bram_wr_addr, bram_we, bram_di, outstanding
  );

  modport master (
    output rd_req_en, rd_req_addr, wr_req_en, wr_req_addr, wr_req_data, rsp_deq,
           bram_do, bram_init,
    input  rd_rdy, wr_rdy, rsp_valid, rsp_data,
           bram_rd_addr, bram_re, bram_wr_addr, bram_we, bram_di, outstanding
  );
endinterface
`default_nettype wire

// File: rtl/bram_port_client.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bram_port_client
//  Purpose  : Initiator side of one BRAM port. Turns a latency-insensitive
//             request/response handshake into BRAM port drives, tracks the
//             read in flight and buffers read data in a response FIFO so a
//             stalled consumer never loses a read. Reads are credit-limited
//             to RSP_DEPTH outstanding; a write wins a same-cycle conflict.
//  Ports    : clka  - clock, all state on rising edge
//             rst_n - asynchronous active-low reset
//             bus   - bram_port_client_if.slave (handshakes + BRAM port)
//  Revision : 1.0 - initial release
// ============================================================================
module bram_port_client #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9,
  parameter int RSP_DEPTH  = 2
) (
  input  wire logic             clka,
  input  wire logic             rst_n,
  bram_port_client_if.slave     bus
);

  localparam int              c_PW    = $clog2(RSP_DEPTH);
  localparam int              c_OW    = c_PW + 1;
  localparam logic [c_OW-1:0] c_DEPTH = c_OW'(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_OW-1:0]       r_count;
  logic [c_OW-1:0]       r_outstanding;
  logic                  r_infl;

  logic w_wr_rdy;
  logic w_rd_rdy;
  logic w_we;
  logic w_re;
  logic w_valid;
  logic w_enq;
  logic w_deq;

  // rst_n is folded in so the ready outputs drop the instant reset asserts.
  assign w_wr_rdy = rst_n & bus.bram_init;
  assign w_rd_rdy = w_wr_rdy & (r_outstanding != c_DEPTH);

  // One op per cycle on the port: the write takes it, the read is left
  // unaccepted and the client keeps presenting it.
  assign w_we = bus.wr_req_en & w_wr_rdy;
  assign w_re = bus.rd_req_en & w_rd_rdy & ~w_we;

  assign w_valid = (r_count != '0);
  // Data from a read issued last cycle is on bram_do now; BRAM_INIT does not
  // gate this, so a read in flight is always captured.
  assign w_enq   = r_infl;
  assign w_deq   = w_valid & bus.rsp_deq;

  assign bus.rd_rdy       = w_rd_rdy;
  assign bus.wr_rdy       = w_wr_rdy;
  assign bus.bram_re      = w_re;
  assign bus.bram_we      = w_we;
  assign bus.bram_rd_addr = bus.rd_req_addr;
  assign bus.bram_wr_addr = bus.wr_req_addr;
  assign bus.bram_di      = bus.wr_req_data;
  assign bus.rsp_valid    = w_valid;
  assign bus.rsp_data     = r_mem[r_rd_ptr];
  assign bus.outstanding  = r_outstanding;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_infl        <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
    end else begin
      r_infl <= w_re;
      // Pointers wrap naturally because RSP_DEPTH is a power of two.
      if (w_enq) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + c_PW'(1);

      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_OW'(1);
        2'b01:   r_count <= r_count - c_OW'(1);
        default: r_count <= r_count;
      endcase

      case ({w_re, w_deq})
        2'b10:   r_outstanding <= r_outstanding + c_OW'(1);
        2'b01:   r_outstanding <= r_outstanding - c_OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Storage has no reset: r_count alone decides which entries are live.
  always_ff @(posedge clka) begin
    if (w_enq) r_mem[r_wr_ptr] <= bus.bram_do;
  end

  // Credits cover both the in-flight read and the buffered entries, so the
  // FIFO can never be written while full without a same-cycle dequeue.
  a_no_overflow: assert property (@(posedge clka) disable iff (!rst_n)
    !(w_enq && !w_deq && (r_count == c_DEPTH)));
  a_outstanding_range: assert property (@(posedge clka) disable iff (!rst_n)
    r_outstanding <= c_DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_bram_port_client.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bram_port_client
//  Purpose  : Self-checking bench for bram_port_client with a behavioural
//             single-port BRAM (1-cycle registered read).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_client;
  localparam int DW = 36;
  localparam int AW = 9;
  localparam int RD = 2;
  localparam int OW = $clog2(RD) + 1;

  logic clka  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clka = ~clka;

  bram_port_client_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)) bus ();

  bram_port_client #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural BRAM: mem[a] = 0xC0 + a at start.
  logic [DW-1:0] mem [512];
  always @(posedge clka) begin
    if (bus.bram_we) mem[bus.bram_wr_addr] <= bus.bram_di;
    if (bus.bram_re) bus.bram_do <= mem[bus.bram_rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          deq;
    logic          init;
    logic          e_rd_rdy;
    logic          e_wr_rdy;
    logic          e_re;
    logic          e_we;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [OW-1:0] e_out;
  } vec_t;

  function automatic vec_t mk(input int rd_en, input int rd_addr, input int wr_en,
                              input int wr_addr, input int wr_data, input int deq,
                              input int init, input int e_rd_rdy, input int e_wr_rdy,
                              input int e_re, input int e_we, input int e_valid,
                              input int e_data, input int e_out);
    vec_t v;
    v.rd_en    = 1'(rd_en);
    v.rd_addr  = AW'(rd_addr);
    v.wr_en    = 1'(wr_en);
    v.wr_addr  = AW'(wr_addr);
    v.wr_data  = DW'(wr_data);
    v.deq      = 1'(deq);
    v.init     = 1'(init);
    v.e_rd_rdy = 1'(e_rd_rdy);
    v.e_wr_rdy = 1'(e_wr_rdy);
    v.e_re     = 1'(e_re);
    v.e_we     = 1'(e_we);
    v.e_valid  = 1'(e_valid);
    v.e_data   = DW'(e_data);
    v.e_out    = OW'(e_out);
    return v;
  endfunction

  task automatic drive(input logic rd_en, input logic [AW-1:0] rd_addr, input logic wr_en,
                       input logic [AW-1:0] wr_addr, input logic [DW-1:0] wr_data,
                       input logic deq);
    bus.rd_req_en   = rd_en;
    bus.rd_req_addr = rd_addr;
    bus.wr_req_en   = wr_en;
    bus.wr_req_addr = wr_addr;
    bus.wr_req_data = wr_data;
    bus.rsp_deq     = deq;
  endtask

  vec_t tv [20];

  initial begin
    int issued;
    int recv;

    for (int i = 0; i < 512; i++) mem[i] = DW'(32'hC0 + i);

    //           rd a  wr a  data  dq in | rrdy wrdy re we val data  out
    tv[0]  = mk(0, 0, 1, 3, 'hA5, 0, 1,   1, 1, 0, 1, 0, 0,    0); // write A5 @3
    tv[1]  = mk(1, 3, 0, 0, 0,    0, 1,   1, 1, 1, 0, 0, 0,    0); // read @3
    tv[2]  = mk(0, 0, 0, 0, 0,    0, 1,   1, 1, 0, 0, 0, 0,    1);
    tv[3]  = mk(0, 0, 0, 0, 0,    0, 1,   1, 1, 0, 0, 1, 'hA5, 1); // N+3
    tv[4]  = mk(0, 0, 0, 0, 0,    1, 1,   1, 1, 0, 0, 1, 'hA5, 1);
    tv[5]  = mk(1, 0, 1, 5, 'h55, 0, 1,   1, 1, 0, 1, 0, 0,    0); // conflict
    tv[6]  = mk(1, 5, 0, 0, 0,    0, 1,   1, 1, 1, 0, 0, 0,    0); // retry
    tv[7]  = mk(0, 0, 0, 0, 0,    0, 1,   1, 1, 0, 0, 0, 0,    1);
    tv[8]  = mk(0, 0, 0, 0, 0,    1, 1,   1, 1, 0, 0, 1, 'h55, 1);
    tv[9]  = mk(0, 0, 0, 0, 0,    0, 1,   1, 1, 0, 0, 0, 0,    0); // one rsp only
    tv[10] = mk(1, 0, 0, 0, 0,    0, 1,   1, 1, 1, 0, 0, 0,    0); // read @0
    tv[11] = mk(1, 1, 0, 0, 0,    0, 1,   1, 1, 1, 0, 0, 0,    1); // read @1
    tv[12] = mk(1, 2, 0, 0, 0,    0, 1,   0, 1, 0, 0, 1, 'hC0, 2); // @2 stalls
    tv[13] = mk(1, 2, 0, 0, 0,    0, 1,   0, 1, 0, 0, 1, 'hC0, 2);
    tv[14] = mk(1, 2, 0, 0, 0,    1, 1,   0, 1, 0, 0, 1, 'hC0, 2); // deq C0
    tv[15] = mk(1, 2, 0, 0, 0,    0, 1,   1, 1, 1, 0, 1, 'hC1, 1); // @2 accepted
    tv[16] = mk(0, 0, 0, 0, 0,    1, 1,   0, 1, 0, 0, 1, 'hC1, 2);
    tv[17] = mk(0, 0, 0, 0, 0,    1, 1,   1, 1, 0, 0, 1, 'hC2, 1);
    tv[18] = mk(0, 0, 0, 0, 0,    0, 1,   1, 1, 0, 0, 0, 0,    0);
    tv[19] = mk(1, 0, 1, 7, 'h77, 0, 0,   0, 0, 0, 0, 0, 0,    0); // BRAM not ready

    // Reset state, with requests presented to show they are gated.
    bus.bram_init = 1'b1;
    drive(1'b1, '0, 1'b1, '0, '0, 1'b0);
    #2;
    chk("rst_rd_rdy", 64'(bus.rd_rdy), 64'(0));
    chk("rst_wr_rdy", 64'(bus.wr_rdy), 64'(0));
    chk("rst_re", 64'(bus.bram_re), 64'(0));
    chk("rst_we", 64'(bus.bram_we), 64'(0));
    chk("rst_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_out", 64'(bus.outstanding), 64'(0));
    @(posedge clka); #1;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd_rdy", 64'(bus.rd_rdy), 64'(1));
    chk("post_rst_wr_rdy", 64'(bus.wr_rdy), 64'(1));
    chk("post_rst_out", 64'(bus.outstanding), 64'(0));

    // Directed vector table, one row per cycle.
    for (int i = 0; i < 20; i++) begin
      @(posedge clka); #1;
      drive(tv[i].rd_en, tv[i].rd_addr, tv[i].wr_en, tv[i].wr_addr, tv[i].wr_data, tv[i].deq);
      bus.bram_init = tv[i].init;
      @(negedge clka);
      chk($sformatf("v%0d_rd_rdy", i), 64'(bus.rd_rdy), 64'(tv[i].e_rd_rdy));
      chk($sformatf("v%0d_wr_rdy", i), 64'(bus.wr_rdy), 64'(tv[i].e_wr_rdy));
      chk($sformatf("v%0d_re", i), 64'(bus.bram_re), 64'(tv[i].e_re));
      chk($sformatf("v%0d_we", i), 64'(bus.bram_we), 64'(tv[i].e_we));
      chk($sformatf("v%0d_valid", i), 64'(bus.rsp_valid), 64'(tv[i].e_valid));
      chk($sformatf("v%0d_out", i), 64'(bus.outstanding), 64'(tv[i].e_out));
      if (tv[i].e_valid) chk($sformatf("v%0d_data", i), 64'(bus.rsp_data), 64'(tv[i].e_data));
    end

    // Mid-operation async reset: one buffered response plus one in flight.
    @(posedge clka); #1;
    bus.bram_init = 1'b1;
    drive(1'b1, AW'(10), 1'b0, '0, '0, 1'b0);
    @(posedge clka); #1;
    drive(1'b1, AW'(11), 1'b0, '0, '0, 1'b0);
    @(posedge clka); #1;
    drive(1'b1, AW'(12), 1'b1, AW'(13), DW'(32'h99), 1'b0);
    chk("pre_rst_valid", 64'(bus.rsp_valid), 64'(1));
    chk("pre_rst_out", 64'(bus.outstanding), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'(0));
    chk("mid_rst_rd_rdy", 64'(bus.rd_rdy), 64'(0));
    chk("mid_rst_wr_rdy", 64'(bus.wr_rdy), 64'(0));
    chk("mid_rst_re", 64'(bus.bram_re), 64'(0));
    chk("mid_rst_we", 64'(bus.bram_we), 64'(0));
    chk("mid_rst_out", 64'(bus.outstanding), 64'(0));
    @(posedge clka); #1;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clka);
      chk($sformatf("after_rst_valid_%0d", i), 64'(bus.rsp_valid), 64'(0));
      chk($sformatf("after_rst_out_%0d", i), 64'(bus.outstanding), 64'(0));
      @(posedge clka); #1;
    end

    // Streaming: 16 reads from @16.., consumer always ready.
    issued = 0;
    recv   = 0;
    for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
      drive(issued < 16, AW'(16 + issued), 1'b0, '0, '0, 1'b1);
      @(negedge clka);
      chk("stream_out_le_depth", 64'(bus.outstanding <= OW'(RD)), 64'(1));
      if (bus.rsp_valid) begin
        chk($sformatf("stream_data_%0d", recv), 64'(bus.rsp_data), 64'(32'hC0 + 16 + recv));
        recv++;
      end
      if (bus.bram_re) issued++;
      @(posedge clka); #1;
    end
    chk("stream_count", 64'(recv), 64'(16));
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    repeat (3) @(posedge clka);
    @(negedge clka);
    chk("stream_drained_valid", 64'(bus.rsp_valid), 64'(0));
    chk("stream_drained_out", 64'(bus.outstanding), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
